rr_priority_encoder: RTL and testbench

- Parametrised, registered successor to the 16-to-4 priority encoder.
- Arbitrates NUM_REQ request lines and returns a held grant (index plus one-hot) under a valid/ack handshake.
- Runtime-selectable fixed-priority (lowest index wins) or round-robin mode.
- Used by issue/LSU stages that pick one of many ready wavefront or queue slots per cycle.

---
 rtl/rr_priority_encoder_pkg.sv | 17 +
 rtl/rr_priority_encoder_penc.sv | 30 +++
 rtl/rr_priority_encoder.sv | 147 ++++++++++++++
 tb/tb_rr_priority_encoder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_priority_encoder_pkg.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder_pkg
// Shared definitions for the round-robin / fixed-priority grant encoder.
//   - Grant FSM state codes (IDLE = no live grant, GRANTED = grant held).
//   - idx_width_for(): helper for callers sizing IDX_WIDTH from NUM_REQ.
// ---------------------------------------------------------------------------
package rr_priority_encoder_pkg;

    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_GRANTED = 1'b1;

    // Smallest index width able to address n requesters (at least 1 bit).
    function automatic int idx_width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : rr_priority_encoder_pkg

// File: rtl/rr_priority_encoder_penc.sv
// ---------------------------------------------------------------------------
// priority_encoder_param
// Combinational lowest-set-bit encoder.
//   req_i   [NUM_REQ-1:0]   input vector
//   found_o                 1 when any bit of req_i is set
//   idx_o   [IDX_WIDTH-1:0] index of the lowest set bit, 0 when none is set
// ---------------------------------------------------------------------------
module priority_encoder_param
    import rr_priority_encoder_pkg::*;
#(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic [NUM_REQ-1:0]   req_i,
    output logic                 found_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    always_comb begin
        found_o = |req_i;
        idx_o   = '0;
        // Scan downward so the lowest set bit is the last one written.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_WIDTH'(i);
            end
        end
    end

endmodule : priority_encoder_param

// File: rtl/rr_priority_encoder.sv
// ---------------------------------------------------------------------------
// rr_priority_encoder
// Registered arbiter: picks one of NUM_REQ requesters and holds the grant
// until it is acknowledged or withdrawn. Fixed priority (index 0 first) or
// round-robin (scan starts at rr_ptr) selectable every arbitration.
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   req           request vector, bit i = requester i
//   enable        permits new grants (a held grant is unaffected)
//   rr_mode       1 = round-robin, 0 = fixed priority
//   ack           consumer accepts the current grant (ignored when idle)
//   grant_valid   a live grant is held
//   grant_idx     index of the granted requester
//   grant_onehot  one-hot of grant_idx, all-zero when no grant is held
//   rr_ptr        round-robin start pointer (debug)
// ---------------------------------------------------------------------------
module rr_priority_encoder
    import rr_priority_encoder_pkg::*;
#(
    parameter int NUM_REQ   = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic                 enable,
    input  logic                 rr_mode,
    input  logic                 ack,
    output logic                 grant_valid,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic [NUM_REQ-1:0]   grant_onehot,
    output logic [IDX_WIDTH-1:0] rr_ptr
);

    // Wrap is against the last real requester, not the top index code.
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_REQ - 1);

    logic [0:0]           state_q,  state_d;
    logic [IDX_WIDTH-1:0] idx_q,    idx_d;
    logic [NUM_REQ-1:0]   onehot_q, onehot_d;
    logic [IDX_WIDTH-1:0] ptr_q,    ptr_d;

    logic [IDX_WIDTH-1:0] ptr_after_ack;
    logic                 acking;
    logic [IDX_WIDTH-1:0] arb_ptr;
    logic [IDX_WIDTH-1:0] start;
    logic [NUM_REQ-1:0]   masked_req;
    logic                 masked_found;
    logic [IDX_WIDTH-1:0] masked_idx;
    logic                 raw_found;
    logic [IDX_WIDTH-1:0] raw_idx;
    logic [IDX_WIDTH-1:0] winner;
    logic [NUM_REQ-1:0]   winner_onehot;
    logic                 held_req_live;

    assign ptr_after_ack = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_WIDTH'(1);
    assign acking        = (state_q == ST_GRANTED) && ack;
    // On an ack the re-arbitration in the same edge must already see the
    // advanced pointer, so bypass the register.
    assign arb_ptr       = acking ? ptr_after_ack : ptr_q;
    assign start         = rr_mode ? arb_ptr : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
            assign masked_req[gi] = req[gi] & (IDX_WIDTH'(gi) >= start);
        end
    endgenerate

    priority_encoder_param #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_penc_masked (
        .req_i   (masked_req),
        .found_o (masked_found),
        .idx_o   (masked_idx)
    );

    priority_encoder_param #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_penc_raw (
        .req_i   (req),
        .found_o (raw_found),
        .idx_o   (raw_idx)
    );

    // Nothing at or above start: wrap around to the lowest request overall.
    assign winner = masked_found ? masked_idx : raw_idx;

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign winner_onehot[gi] = (winner == IDX_WIDTH'(gi));
        end
    endgenerate

    // onehot_q selects exactly the granted line, avoiding a wide index mux.
    assign held_req_live = |(req & onehot_q);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        onehot_d = onehot_q;
        ptr_d    = ptr_q;
        if (state_q == ST_IDLE) begin
            if (enable && raw_found) begin
                state_d  = ST_GRANTED;
                idx_d    = winner;
                onehot_d = winner_onehot;
            end
        end else begin
            if (ack) begin
                ptr_d = ptr_after_ack;
                if (enable && raw_found) begin
                    idx_d    = winner;
                    onehot_d = winner_onehot;
                end else begin
                    state_d  = ST_IDLE;
                    onehot_d = '0;
                end
            end else if (!held_req_live) begin
                state_d  = ST_IDLE;
                onehot_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            onehot_q <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            onehot_q <= onehot_d;
            ptr_q    <= ptr_d;
        end
    end

    assign grant_valid  = (state_q == ST_GRANTED);
    assign grant_idx    = idx_q;
    assign grant_onehot = onehot_q;
    assign rr_ptr       = ptr_q;

endmodule : rr_priority_encoder

// File: tb/tb_rr_priority_encoder.sv
module tb_rr_priority_encoder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // 16-requester instance
    logic [15:0] req16 = '0;
    logic        en16 = 1'b0, rr16 = 1'b0, ack16 = 1'b0;
    logic        gv16;
    logic [3:0]  gi16, ptr16;
    logic [15:0] goh16;

    // 5-requester instance (non-power-of-2)
    logic [4:0]  req5 = '0;
    logic        en5 = 1'b0, rr5 = 1'b0, ack5 = 1'b0;
    logic        gv5;
    logic [2:0]  gi5, ptr5;
    logic [4:0]  goh5;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit m16_v = 0; int m16_idx = 0; int m16_ptr = 0;
    bit m5_v  = 0; int m5_idx  = 0; int m5_ptr  = 0;

    always #5 clk = ~clk;

    rr_priority_encoder #(.NUM_REQ(16), .IDX_WIDTH(4)) dut16 (
        .clk(clk), .rst(rst), .req(req16), .enable(en16), .rr_mode(rr16),
        .ack(ack16), .grant_valid(gv16), .grant_idx(gi16),
        .grant_onehot(goh16), .rr_ptr(ptr16)
    );

    rr_priority_encoder #(.NUM_REQ(5), .IDX_WIDTH(3)) dut5 (
        .clk(clk), .rst(rst), .req(req5), .enable(en5), .rr_mode(rr5),
        .ack(ack5), .grant_valid(gv5), .grant_idx(gi5),
        .grant_onehot(goh5), .rr_ptr(ptr5)
    );

    // First requester at or after 'start' in circular order, -1 if none.
    function automatic int find_first(input logic [15:0] r, input int start, input int n);
        for (int k = 0; k < n; k++) begin
            int j;
            j = (start + k) % n;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [15:0] r, input bit en, input bit rr,
                              input bit ak, input int n,
                              inout bit v, inout int idx, inout int ptr);
        int w;
        if (!v) begin
            w = find_first(r, rr ? ptr : 0, n);
            if (en && w >= 0) begin
                v = 1; idx = w;
            end
        end else if (ak) begin
            ptr = (idx + 1) % n;
            w = find_first(r, rr ? ptr : 0, n);
            if (en && w >= 0) idx = w;
            else v = 0;
        end else if (!r[idx]) begin
            v = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check16();
        check("v16", {31'b0, gv16}, {31'b0, m16_v});
        if (m16_v) check("idx16", {28'b0, gi16}, m16_idx);
        check("oh16", {16'b0, goh16}, m16_v ? (32'd1 << m16_idx) : 32'd0);
        check("ptr16", {28'b0, ptr16}, m16_ptr);
    endtask

    task automatic check5();
        check("v5", {31'b0, gv5}, {31'b0, m5_v});
        if (m5_v) check("idx5", {29'b0, gi5}, m5_idx);
        check("oh5", {27'b0, goh5}, m5_v ? (32'd1 << m5_idx) : 32'd0);
        check("ptr5", {29'b0, ptr5}, m5_ptr);
    endtask

    task automatic tick();
        model_step(req16, en16, rr16, ack16, 16, m16_v, m16_idx, m16_ptr);
        model_step({11'b0, req5}, en5, rr5, ack5, 5, m5_v, m5_idx, m5_ptr);
        @(posedge clk);
        #1;
        check16();
        check5();
        $display("t=%0t req16=%h gv16=%0d gi16=%0d ptr16=%0d | req5=%b gv5=%0d gi5=%0d ptr5=%0d",
                 $time, req16, gv16, gi16, ptr16, req5, gv5, gi5, ptr5);
    endtask

    initial begin
        // Reset state
        #12 rst = 1'b0;
        check("rst_v", {31'b0, gv16}, 0);
        check("rst_oh", {16'b0, goh16}, 0);
        check("rst_ptr", {28'b0, ptr16}, 0);
        check16();
        check5();

        // Empty request: nothing granted, no X
        en16 = 1; req16 = '0;
        repeat (3) tick();
        check("empty_nox", {31'b0, ^{gv16, gi16, goh16, ptr16} === 1'bx}, 0);

        // Enable gating
        en16 = 0; req16 = 16'h0100;
        repeat (3) tick();
        check("gate_v", {31'b0, gv16}, 0);
        en16 = 1;
        tick();
        check("gate_idx", {28'b0, gi16}, 8);
        ack16 = 1; req16 = '0;
        tick();
        check("gate_ack_v", {31'b0, gv16}, 0);
        ack16 = 0;

        // Fixed priority
        rr16 = 0; en16 = 1; req16 = 16'h0A50;
        tick();
        check("fp_idx", {28'b0, gi16}, 4);
        check("fp_oh", {16'b0, goh16}, 32'h0010);
        ack16 = 1;
        tick();
        check("fp_idx2", {28'b0, gi16}, 4);
        check("fp_ptr", {28'b0, ptr16}, 5);
        ack16 = 0; req16 = '0;
        tick();

        // Async reset mid-grant
        req16 = 16'h0020;
        tick();
        check("pre_rst_idx", {28'b0, gi16}, 5);
        #2 rst = 1'b1;
        #1;
        check("arst_v", {31'b0, gv16}, 0);
        check("arst_oh", {16'b0, goh16}, 0);
        check("arst_ptr", {28'b0, ptr16}, 0);
        m16_v = 0; m16_idx = 0; m16_ptr = 0;
        m5_v = 0; m5_idx = 0; m5_ptr = 0;
        #1 rst = 1'b0;

        // Round-robin rotation
        rr16 = 1; en16 = 1; req16 = 16'h8421; ack16 = 0;
        tick();
        check("rr_idx0", {28'b0, gi16}, 0);
        ack16 = 1;
        tick(); check("rr_idx5",  {28'b0, gi16}, 5);  check("rr_ptr1",  {28'b0, ptr16}, 1);
        tick(); check("rr_idx10", {28'b0, gi16}, 10); check("rr_ptr6",  {28'b0, ptr16}, 6);
        tick(); check("rr_idx15", {28'b0, gi16}, 15); check("rr_ptr11", {28'b0, ptr16}, 11);
        tick(); check("rr_idxw0", {28'b0, gi16}, 0);  check("rr_ptr0",  {28'b0, ptr16}, 0);
        check("rr_v", {31'b0, gv16}, 1);

        // Hold and withdrawal
        req16 = 16'h0008;
        tick();
        check("hold_idx3", {28'b0, gi16}, 3);
        ack16 = 0; en16 = 0; req16 = 16'h000A;
        tick(); tick();
        check("hold_stable", {28'b0, gi16}, 3);
        req16 = 16'h0002;
        tick();
        check("wd_v", {31'b0, gv16}, 0);
        check("wd_ptr", {28'b0, ptr16}, 1);
        req16 = '0;

        // Non-power-of-2 wrap
        rr5 = 1; en5 = 1; req5 = 5'b10001;
        tick(); check("np2_0", {29'b0, gi5}, 0);
        ack5 = 1;
        tick(); check("np2_4", {29'b0, gi5}, 4);
        tick(); check("np2_0b", {29'b0, gi5}, 0); check("np2_ptr", {29'b0, ptr5}, 0);
        ack5 = 0;

        // Randomized traffic on both instances
        for (int i = 0; i < 300; i++) begin
            req16 = 16'($urandom) & 16'($urandom);
            en16  = ($urandom_range(0, 3) != 0);
            rr16  = 1'($urandom);
            ack16 = 1'($urandom);
            req5  = 5'($urandom) & 5'($urandom);
            en5   = ($urandom_range(0, 3) != 0);
            rr5   = 1'($urandom);
            ack5  = 1'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_rr_priority_encoder
